// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake: pc_sequencer drives req/addr as master, imem returns ack as slave.
interface pc_sequencer_if #(
  parameter int N = 32
) ();
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC, sequences imem fetches and picks flush > jump > branch > sequential.
// Optional redirect alignment check is enabled by defining PCSEQ_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter int           N          = 32,
  parameter int           STEP       = 4,
  parameter logic [N-1:0] RESET_ADDR = {N{1'b0}}
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall,
  input  logic           flush,
  input  logic [N-1:0]   flush_addr,
  input  logic           jump,
  input  logic [N-1:0]   jump_addr,
  input  logic           branch_taken,
  input  logic [N-1:0]   branch_addr,
  pc_sequencer_if.master imem,
  output logic [N-1:0]   pc,
  output logic           pc_sel,
  output logic           inst_valid,
  output logic           misalign_err
);

  localparam logic [N-1:0] STEP_W = N'(STEP);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t       state_r, state_nxt_s;
  logic [N-1:0] pc_r, pc_nxt_s, seq_addr_s, tgt_s, upd_addr_s;
  logic [N-1:0] pend_addr_r, pend_addr_nxt_s;
  logic         pc_sel_r, pc_sel_nxt_s;
  logic         pend_r, pend_nxt_s;
  logic         imem_req_r, inst_valid_r;
  logic         misalign_r, misalign_nxt_s;
  logic         redir_s, upd_s, upd_redir_s;

`ifdef PCSEQ_ALIGN_CHECK_EN
  function automatic logic target_misaligned(input logic [N-1:0] addr);
    return (addr % STEP_W) != {N{1'b0}};
  endfunction
`endif

  assign seq_addr_s = pc_r + STEP_W;

  // Redirect target for a regular update cycle, fixed priority
  always_comb begin
    redir_s = 1'b1;
    tgt_s   = flush_addr;
    if (flush) begin
      tgt_s = flush_addr;
    end else if (jump) begin
      tgt_s = jump_addr;
    end else if (branch_taken) begin
      tgt_s = branch_addr;
    end else begin
      redir_s = 1'b0;
      tgt_s   = seq_addr_s;
    end
  end

  // Fetch FSM next state; a flush during REQ is parked until the ack so the response can be dropped
  always_comb begin
    state_nxt_s     = state_r;
    pend_nxt_s      = pend_r;
    pend_addr_nxt_s = pend_addr_r;
    upd_s           = 1'b0;
    upd_redir_s     = redir_s;
    upd_addr_s      = tgt_s;
    case (state_r)
      BOOT: begin
        state_nxt_s = REQ;
      end
      REQ: begin
        if (imem.imem_ack) begin
          if (pend_r || flush) begin
            upd_s       = 1'b1;
            upd_redir_s = 1'b1;
            upd_addr_s  = flush ? flush_addr : pend_addr_r;
            pend_nxt_s  = 1'b0;
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = VALID;
          end
        end else if (flush) begin
          pend_nxt_s      = 1'b1;
          pend_addr_nxt_s = flush_addr;
        end else begin
          pend_nxt_s = pend_r;
        end
      end
      VALID, HOLD: begin
        if (flush || !stall) begin
          upd_s       = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // PC and selector for the update cycle, including optional rejection of misaligned redirects
  always_comb begin
    pc_nxt_s       = pc_r;
    pc_sel_nxt_s   = pc_sel_r;
    misalign_nxt_s = 1'b0;
    if (upd_s && upd_redir_s) begin
`ifdef PCSEQ_ALIGN_CHECK_EN
      if (target_misaligned(upd_addr_s)) begin
        pc_nxt_s       = seq_addr_s;
        pc_sel_nxt_s   = 1'b0;
        misalign_nxt_s = 1'b1;
      end else begin
        pc_nxt_s     = upd_addr_s;
        pc_sel_nxt_s = 1'b1;
      end
`else
      pc_nxt_s     = upd_addr_s;
      pc_sel_nxt_s = 1'b1;
`endif
    end else if (upd_s) begin
      pc_nxt_s     = seq_addr_s;
      pc_sel_nxt_s = 1'b0;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // State, PC and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= BOOT;
      pc_r         <= RESET_ADDR;
      pc_sel_r     <= 1'b0;
      pend_r       <= 1'b0;
      pend_addr_r  <= RESET_ADDR;
      imem_req_r   <= 1'b0;
      inst_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pc_sel_r     <= pc_sel_nxt_s;
      pend_r       <= pend_nxt_s;
      pend_addr_r  <= pend_addr_nxt_s;
      imem_req_r   <= (state_nxt_s == REQ);
      inst_valid_r <= (state_nxt_s == VALID) || (state_nxt_s == HOLD);
      misalign_r   <= misalign_nxt_s;
    end
  end

  assign pc             = pc_r;
  assign pc_sel         = pc_sel_r;
  assign inst_valid     = inst_valid_r;
  assign misalign_err   = misalign_r;
  assign imem.imem_req  = imem_req_r;
  assign imem.imem_addr = pc_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed fetch scenarios plus randomized control traffic.
module tb_pc_sequencer;
  localparam int          N     = 32;
  localparam logic [31:0] RST_A = 32'h0000_0000;

  localparam int P_BOOT  = 0;
  localparam int P_FETCH = 1;
  localparam int P_VALID = 2;
  localparam int P_HOLD  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, jump = 1'b0, branch_taken = 1'b0;
  logic [31:0] flush_addr = 32'h0, jump_addr = 32'h0, branch_addr = 32'h0;
  logic [31:0] pc;
  logic        pc_sel, inst_valid, misalign_err;

  pc_sequencer_if #(.N(N)) bus ();

  pc_sequencer #(.N(N), .STEP(4), .RESET_ADDR(RST_A)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .flush_addr   (flush_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus),
    .pc           (pc),
    .pc_sel       (pc_sel),
    .inst_valid   (inst_valid),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        sel;
    logic        iv;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_sel, m_mis, m_pend;
  logic [31:0] m_pend_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = P_BOOT; m_pc = RST_A; m_sel = 1'b0; m_mis = 1'b0;
    m_pend = 1'b0; m_pend_addr = RST_A;
  endtask

  // Take a PC decision: redirect to t if allowed, else fall through sequentially
  task automatic m_apply(input bit redir, input logic [31:0] t);
    logic [31:0] seq;
    bit          bad;
    seq = m_pc + 32'd4;
    bad = 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
    bad = redir && ((t % 32'd4) != 32'd0);
`endif
    if (bad) begin
      m_pc = seq; m_sel = 1'b0; m_mis = 1'b1;
    end else if (redir) begin
      m_pc = t; m_sel = 1'b1;
    end else begin
      m_pc = seq; m_sel = 1'b0;
    end
    m_phase = P_FETCH;
  endtask

  task automatic m_pick();
    if (flush)             m_apply(1'b1, flush_addr);
    else if (jump)         m_apply(1'b1, jump_addr);
    else if (branch_taken) m_apply(1'b1, branch_addr);
    else                   m_apply(1'b0, 32'h0);
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_reset();
    end else begin
      m_mis = 1'b0;
      case (m_phase)
        P_BOOT: m_phase = P_FETCH;
        P_FETCH: begin
          if (bus.imem_ack) begin
            if (m_pend || flush) begin
              m_apply(1'b1, flush ? flush_addr : m_pend_addr);
              m_pend = 1'b0;
            end else begin
              m_phase = P_VALID;
            end
          end else if (flush) begin
            m_pend = 1'b1; m_pend_addr = flush_addr;
          end
        end
        P_VALID: begin
          if (flush)      m_pick();
          else if (stall) m_phase = P_HOLD;
          else            m_pick();
        end
        P_HOLD: begin
          if (flush || !stall) m_pick();
        end
        default: m_phase = P_BOOT;
      endcase
    end
  endtask

  // One clock: model sees the same inputs the DUT samples; expectation goes to the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    e.req  = (m_phase == P_FETCH);
    e.addr = m_pc;
    e.pc   = m_pc;
    e.sel  = m_sel;
    e.iv   = (m_phase == P_VALID) || (m_phase == P_HOLD);
    e.mis  = m_mis;
    q.push_back(e);
    #1;
  endtask

  task automatic fetch(input int delay);
    for (int i = 0; i < delay; i++) begin
      bus.imem_ack = 1'b0;
      tick();
      chk("req_stable", {31'b0, bus.imem_req}, 32'd1);
    end
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
  endtask

  task automatic adv(input logic j, input logic [31:0] ja, input logic b, input logic [31:0] ba);
    jump = j; jump_addr = ja; branch_taken = b; branch_addr = ba;
    tick();
    jump = 1'b0; branch_taken = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_0FFC;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // Scoreboard monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_req",     {31'b0, bus.imem_req}, {31'b0, e.req});
      chk("imem_addr",    bus.imem_addr, e.addr);
      chk("pc",           pc, e.pc);
      chk("pc_sel",       {31'b0, pc_sel}, {31'b0, e.sel});
      chk("inst_valid",   {31'b0, inst_valid}, {31'b0, e.iv});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int iv_cnt;
    bus.imem_ack = 1'b0;
    m_reset();
    tick();
    chk("rst_pc", pc, RST_A);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_iv", {31'b0, inst_valid}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    tick();                         // BOOT -> REQ
    chk("boot_req", {31'b0, bus.imem_req}, 32'd1);
    fetch(0); adv(0, 0, 0, 0);      // 0x0
    fetch(0); adv(0, 0, 0, 0);      // 0x4
    chk("seq_addr_8", bus.imem_addr, 32'h8);
    fetch(3);                       // 0x8, delayed ack
    chk("delay_iv", {31'b0, inst_valid}, 32'd1);
    adv(0, 0, 0, 0);
    chk("delay_iv_once", {31'b0, inst_valid}, 32'd0);
    fetch(0); adv(0, 0, 0, 0);      // 0xC
    fetch(0);                       // 0x10
    adv(1, 32'h40, 1, 32'h80);
    chk("jump_pc", pc, 32'h40);
    chk("jump_sel", {31'b0, pc_sel}, 32'd1);
    fetch(0);
    adv(0, 0, 1, 32'h80);
    chk("branch_pc", pc, 32'h80);

    fetch(0);
    flush = 1'b1; flush_addr = 32'h20; tick(); flush = 1'b0;
    fetch(0);                       // 0x20, then stall 4 cycles
    iv_cnt = inst_valid ? 1 : 0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_valid) iv_cnt++;
      chk("stall_pc", pc, 32'h20);
    end
    stall = 1'b0;
    tick();
    chk("stall_iv_cycles", iv_cnt, 32'd5);
    chk("stall_release_pc", pc, 32'h24);

    fetch(0); adv(1, 32'h30, 0, 0);
    flush = 1'b1; flush_addr = 32'h100; tick(); flush = 1'b0;
    tick();
    bus.imem_ack = 1'b1; tick(); bus.imem_ack = 1'b0;
    chk("flush_drop_iv", {31'b0, inst_valid}, 32'd0);
    chk("flush_addr", bus.imem_addr, 32'h100);
    chk("flush_sel", {31'b0, pc_sel}, 32'd1);

    fetch(0); adv(1, 32'h50, 0, 0);
    fetch(0); adv(1, 32'h42, 0, 0);
`ifdef PCSEQ_ALIGN_CHECK_EN
    chk("misalign_pc", pc, 32'h54);
    chk("misalign_err", {31'b0, misalign_err}, 32'd1);
`else
    chk("misalign_pc", pc, 32'h42);
    chk("misalign_err", {31'b0, misalign_err}, 32'd0);
`endif
    fetch(0);
    flush = 1'b1; flush_addr = 32'hFFFF_FFFC; tick(); flush = 1'b0;
    chk("misalign_pulse", {31'b0, misalign_err}, 32'd0);
    fetch(0); adv(0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_sel", {31'b0, pc_sel}, 32'd0);

    // Asynchronous reset in the middle of a fetch, with an ack in flight
    fetch(0); adv(1, 32'h200, 0, 0);
    bus.imem_ack = 1'b0; tick();
    #1 rst_n = 1'b0;
    q.delete();
    m_reset();
    #1;
    chk("arst_pc", pc, RST_A);
    chk("arst_addr", bus.imem_addr, RST_A);
    chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("arst_sel", {31'b0, pc_sel}, 32'd0);
    bus.imem_ack = 1'b1;
    tick();
    chk("arst_iv", {31'b0, inst_valid}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1; bus.imem_ack = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      stall        = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      flush_addr   = rand_addr();
      jump         = ($urandom_range(0, 5) == 0);
      jump_addr    = rand_addr();
      branch_taken = ($urandom_range(0, 5) == 0);
      branch_addr  = rand_addr();
      bus.imem_ack = (m_phase == P_FETCH) && ($urandom_range(0, 9) < 4);
      tick();
    end
    stall = 1'b0; flush = 1'b0; jump = 1'b0; branch_taken = 1'b0; bus.imem_ack = 1'b0;
    tick();
    @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the CPU fetch stage. It owns the program counter register and drives the PC mux select. It sequences instruction-memory fetches with a req/ack handshake and chooses among the sequential, branch, jump and flush targets with a fixed priority. It sits between the control unit (branch/jump decisions) and instruction memory, upstream of the PC mux.

## Interface
Parameters:
- N, 32, PC and address width in bits
- STEP, 4, sequential increment in bytes
- RESET_ADDR, 32'h00000000, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold current instruction; no PC advance
- flush  in  1  pipeline redirect, highest priority
- flush_addr  in  N  flush target
- jump  in  1  jump request
- jump_addr  in  N  jump target
- branch_taken  in  1  taken branch
- branch_addr  in  N  branch target
- imem_req  out  1  fetch request
- imem_addr  out  N  fetch address, equals pc
- imem_ack  in  1  fetch complete; instruction valid this cycle
- pc  out  N  current program counter
- pc_sel  out  1  1 = a redirect target was chosen at the last PC update; 0 = sequential
- inst_valid  out  1  fetched instruction for pc is valid downstream
- misalign_err  out  1  redirect target not STEP-aligned (see Configuration)

## Operation
- States: BOOT, REQ, VALID, HOLD.
- BOOT: entered on reset. Leaves to REQ on the first clock edge after rst_n deasserts.
- REQ: imem_req=1 and imem_addr=pc, both held stable until imem_ack. On imem_ack, go to VALID unless a pending flush is set (see below).
- VALID: inst_valid=1 for this cycle.
  - If stall=1, go to HOLD.
  - Otherwise update pc and go to REQ.
- HOLD: inst_valid=1, pc unchanged. Stay while stall=1. When stall=0, update pc and go to REQ.
- PC update priority, sampled only on the update cycle: flush > jump > branch_taken > sequential.
  - Sequential target is pc + STEP, modulo 2^N; 32'hFFFFFFFC wraps to 0.
  - pc_sel=1 for any non-sequential choice. It is registered with pc and holds until the next update.
- flush is also accepted in REQ, BOOT and HOLD:
  - In HOLD: immediate update to flush_addr, ignoring stall. Go to REQ.
  - In REQ before ack: latch flush_addr into a pending register and keep imem_req/imem_addr unchanged. On ack, drop the response (inst_valid stays 0), load pc from the pending register, go to REQ.
  - Flush on the same cycle as ack: treated as pending, so the response is dropped.
  - In BOOT: ignored.
- jump and branch_taken outside an update cycle: ignored.

## Timing
- Reset values: pc=RESET_ADDR, pc_sel=0, imem_req=0, imem_addr=RESET_ADDR, inst_valid=0, misalign_err=0. Pending-flush register is cleared.
- Reset asserted mid-fetch: all of the above take effect immediately. Any ack in flight is ignored.
- Minimum fetch cycle, with ack in the first REQ cycle: REQ → VALID → REQ, giving 2 clocks per instruction.
- The new pc is visible the cycle after the update cycle, together with imem_req=1.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- PCSEQ_ALIGN_CHECK_EN defined:
  - On an update cycle whose chosen redirect target has addr % STEP != 0, the redirect is rejected and pc takes the sequential target (pc_sel=0).
  - misalign_err pulses 1 for one cycle, the cycle after the update.
- PCSEQ_ALIGN_CHECK_EN undefined: any target is accepted unmodified and misalign_err is tied to 0.

## Test plan
- Reset then free-run with ack in the first REQ cycle: imem_addr sequence 0x0, 0x4, 0x8, one fetch every 2 clocks; pc_sel=0; inst_valid toggles 0/1.
- Ack delayed 3 cycles at pc=0x8: imem_req and imem_addr=0x8 stable for all 3 cycles. After the ack, inst_valid=1 for exactly 1 cycle.
- In VALID at pc=0x10, assert jump=1 with jump_addr=0x40 and branch_taken=1 with branch_addr=0x80: next pc=0x40, pc_sel=1. Repeat with the branch only: next pc=0x80.
- Stall for 4 cycles in VALID at pc=0x20: pc held, inst_valid=1 for 5 cycles. On release, pc=0x24.
- flush with flush_addr=0x100 two cycles before the ack of the pc=0x30 fetch: that ack yields no inst_valid; next imem_addr=0x100, pc_sel=1.
- With PCSEQ_ALIGN_CHECK_EN, jump_addr=0x42 at pc=0x50: pc=0x54, misalign_err=1 for one cycle. Without the macro: pc=0x42, misalign_err=0. Also check pc=0xFFFFFFFC sequential wraps to 0x0.
